serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Multi-cycle parametrised adder for WIDTH-bit operands. Each cycle it processes BITS_PER_CYCLE bits through a chain of one-bit full-adder cells and keeps the carry in a register between cycles.
Uses a start/busy/done handshake. Trades latency for area in datapaths where a full-width ripple or carry-lookahead adder is too large.

Parameters:
WIDTH, 8, operand and sum width in bits; must be ≥ 2.
BITS_PER_CYCLE, 1, bits processed per cycle; WIDTH must be an integer multiple of it.
STEPS (localparam), WIDTH/BITS_PER_CYCLE, number of processing cycles.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  request a new operation; sampled only when busy=0.
a  input  WIDTH  operand A; captured on the accepting edge.
b  input  WIDTH  operand B; captured on the accepting edge.
cin  input  1  carry-in; captured on the accepting edge.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse; result valid.
sum  output  WIDTH  result; held until the next accepted start.
cout  output  1  carry out of bit WIDTH-1.
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: state=IDLE. busy=0, done=0, sum=0, cout=0, ovf=0. Operand shift registers and carry register are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: latch a, b and cin (carry reg = cin), step counter=0, next state RUN. Otherwise stay in IDLE.
- RUN, each edge:
  - Add the low BITS_PER_CYCLE bits of the A/B shift registers plus the carry reg.
  - Shift the result chunk into the sum shift register from the MSB end.
  - Shift the A/B registers right by BITS_PER_CYCLE.
  - Update the carry reg and increment the counter.
  - On the edge where counter == STEPS-1, next state is DONE.
  - On that final chunk, also record the carry into the MSB so ovf can be formed.
- DONE: done=1 for exactly one cycle; sum, cout and ovf are valid.
  - If start=1 in DONE, capture new operands and go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- Latency: start high in cycle 0 → busy high in cycles 1..STEPS → done high in cycle STEPS+1.
- Back-to-back throughput: one result per STEPS+1 cycles.
- busy=1 exactly when state=RUN.
- start while busy=1 is ignored; no queuing.
- sum, cout and ovf are held stable from DONE until the next RUN begins. While in RUN they are don't-care; the bench must not check them then.
- Arithmetic is modulo 2^WIDTH; a, b and sum are unsigned, with ovf interpreting them as two's complement.
- rst asserted in any state, including mid-RUN: abort and return to reset values on that edge. No done pulse is produced.

Optional Feature:
Macro SERIAL_ADDER_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), captured with the operands.
  - If sub=1, the block computes a - b: B is captured inverted and the carry reg is initialised to 1, ignoring cin.
  - cout=1 means no borrow; ovf is the signed subtraction overflow.
- When undefined: no sub port; the block adds only.

Decomposition:
- Package serial_adder_pkg:
  - State enum typedef (IDLE, RUN, DONE).
  - Function computing the counter width, $clog2(STEPS) with a minimum of 1.
- One sub-module, fa_bit (a, b, ci → s, co, purely combinational). It is instantiated BITS_PER_CYCLE times in a generate loop to form the per-cycle ripple chunk.

Test Plan:
1. WIDTH=8, BPC=1: a=0x0F, b=0x01, cin=0, start in cycle 0 → done only in cycle 9, busy in cycles 1-8; sum=0x10, cout=0, ovf=0.
2. WIDTH=8, BPC=1: 0xFF+0x01, cin=0 → sum=0x00, cout=1, ovf=0. Then 0x7F+0x01 → sum=0x80, cout=0, ovf=1. Then 0x80+0x80 → sum=0x00, cout=1, ovf=1.
3. WIDTH=4, BPC=2, exhaustive a, b, cin (512 ops, back-to-back by holding start) → every result matches {cout,sum}=a+b+cin; done every 3 cycles.
4. Start pulses during busy → ignored: exactly one done, result from the first operands. rst in cycle 3 of a RUN → busy=0 and outputs zero on the next cycle, no done; a fresh op afterwards completes correctly.
5. WIDTH=8, BPC=8 (STEPS=1): 0xAA+0x55, cin=1 → done in cycle 2; sum=0x00, cout=1.
6. SERIAL_ADDER_SUB_EN defined: a=0x05, b=0x07, sub=1 → sum=0xFE, cout=0, ovf=0. a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, ovf=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the multi-cycle serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter width: enough to count STEPS cycles, never narrower than one bit.
    function automatic int cnt_width(input int steps);
        if (steps <= 2) begin
            return 1;
        end
        return $clog2(steps);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the serial adder (start/busy/done handshake).
// Latency: n/a (wiring only).
// Backpressure: none; start is only honoured while the adder is not busy.
// Optional port sub exists when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_fa_bit.sv
// One-bit full-adder cell used to build the per-cycle ripple chunk.
// Latency: combinational.
// Backpressure: none.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: BITS_PER_CYCLE bits per cycle, carry kept in a register.
// Latency: start in cycle 0 -> busy cycles 1..STEPS -> done pulse in cycle STEPS+1.
// Backpressure: start ignored while busy; SERIAL_ADDER_SUB_EN adds a-b mode.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = cnt_width(STEPS);

    state_t                    state_q, state_d;
    logic                      run_st, done_st, load, last;
    logic [WIDTH-1:0]          a_sh, b_sh, sum_sh, sum_nxt, chunk_ext, b_in;
    logic                      carry_q, ovf_q, c_in;
    logic [CW-1:0]             cnt_q;
    logic [BITS_PER_CYCLE:0]   c;
    logic [BITS_PER_CYCLE-1:0] chunk_s;

    assign last = (cnt_q == CW'(STEPS - 1));

    // Ripple chunk: carry register feeds cell 0, each cell carries into the next.
    assign c[0] = carry_q;
    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_fa
        fa_bit u_fa (
            .a  (a_sh[i]),
            .b  (b_sh[i]),
            .ci (c[i]),
            .s  (chunk_s[i]),
            .co (c[i+1])
        );
    end

    // New chunk enters the sum register from the MSB end.
    assign chunk_ext = WIDTH'(chunk_s);
    assign sum_nxt   = (sum_sh >> BITS_PER_CYCLE) | (chunk_ext << (WIDTH - BITS_PER_CYCLE));

    // Operand conditioning: subtraction is a + ~b + 1.
    always_comb begin
        b_in = bus.b;
        c_in = bus.cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (bus.sub) begin
            b_in = ~bus.b;
            c_in = 1'b1;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; DONE may reload for back-to-back ops.
    always_comb begin
        state_d = state_q;
        run_st  = 1'b0;
        done_st = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                run_st = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_st = 1'b1;
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture operands, then shift one chunk per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (load) begin
            a_sh    <= bus.a;
            b_sh    <= b_in;
            carry_q <= c_in;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            a_sh    <= a_sh >> BITS_PER_CYCLE;
            b_sh    <= b_sh >> BITS_PER_CYCLE;
            sum_sh  <= sum_nxt;
            carry_q <= c[BITS_PER_CYCLE];
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
                // Carry into the MSB differs from carry out: signed overflow.
                ovf_q <= c[BITS_PER_CYCLE-1] ^ c[BITS_PER_CYCLE];
            end
        end
    end

    assign bus.busy = run_st;
    assign bus.done = done_st;
    assign bus.sum  = sum_sh;
    assign bus.cout = carry_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder in three shapes (8/1, 4/2, 8/8).
// Latency: checks done timing against STEPS+1.
// Backpressure: checks start-while-busy is ignored; sub rows need SERIAL_ADDER_SUB_EN.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(4)) bus4 ();
    serial_adder_if #(.WIDTH(8)) bus88 ();

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_add8  (.clk(clk), .rst(rst), .bus(bus8));
    serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(2)) u_add4  (.clk(clk), .rst(rst), .bus(bus4));
    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(8)) u_add88 (.clk(clk), .rst(rst), .bus(bus88));

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] e_sum;
        logic       e_cout;
        logic       e_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One operation on the 8-bit/1-bit-per-cycle adder; cycle 0 is the start cycle.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic s,
                       output int done_cyc, output int busy_cnt,
                       output logic [7:0] sm, output logic co, output logic ov);
        @(posedge clk); #1;
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        bus8.cin   = ci;
`ifdef SERIAL_ADDER_SUB_EN
        bus8.sub   = s;
`else
        if (s) $display("note: sub row without SERIAL_ADDER_SUB_EN");
`endif
        done_cyc = -1;
        busy_cnt = 0;
        sm = '0; co = 1'b0; ov = 1'b0;
        for (int cyc = 1; cyc <= 20 && done_cyc < 0; cyc++) begin
            @(posedge clk); #1;
            bus8.start = 1'b0;
            if (bus8.busy) busy_cnt++;
            if (bus8.done) begin
                done_cyc = cyc;
                sm = bus8.sum;
                co = bus8.cout;
                ov = bus8.ovf;
            end
        end
    endtask

    initial begin
        int         dcyc, bcnt, dn_cnt;
        logic [7:0] sm;
        logic       co, ov, b1, b2, dn;
        logic [4:0] tmp;
        logic [3:0] ea, eb;
        logic       ec, eovf;
        logic [8:0] k9;

        bus8.start = 0;  bus8.a = 0;  bus8.b = 0;  bus8.cin = 0;
        bus4.start = 0;  bus4.a = 0;  bus4.b = 0;  bus4.cin = 0;
        bus88.start = 0; bus88.a = 0; bus88.b = 0; bus88.cin = 0;
`ifdef SERIAL_ADDER_SUB_EN
        bus8.sub = 0; bus4.sub = 0; bus88.sub = 0;
`endif

        tbl.push_back('{"t1_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0});
        tbl.push_back('{"t2_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
        tbl.push_back('{"t2_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
        tbl.push_back('{"t2_80_80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
        tbl.push_back('{"a5_5a_c1", 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
        tbl.push_back('{"sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0});
        tbl.push_back('{"sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1});
`endif

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", 32'(bus8.busy), 0);
        check("rst_done", 32'(bus8.done), 0);
        check("rst_sum",  32'(bus8.sum), 0);
        check("rst_cout", 32'(bus8.cout), 0);
        check("rst_ovf",  32'(bus8.ovf), 0);

        // Table-driven single operations on the 8/1 adder.
        foreach (tbl[i]) begin
            op8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, dcyc, bcnt, sm, co, ov);
            check({tbl[i].name, "_done_cyc"}, 32'(dcyc), 9);
            check({tbl[i].name, "_busy_cnt"}, 32'(bcnt), 8);
            check({tbl[i].name, "_sum"},  32'(sm), 32'(tbl[i].e_sum));
            check({tbl[i].name, "_cout"}, 32'(co), 32'(tbl[i].e_cout));
            check({tbl[i].name, "_ovf"},  32'(ov), 32'(tbl[i].e_ovf));
        end
        // Result must hold after done while idle (last table row).
        repeat (3) @(posedge clk);
        #1;
        check("hold_sum", 32'(bus8.sum), 32'(tbl[tbl.size()-1].e_sum));

        // Start pulses while busy are ignored.
        @(posedge clk); #1;
        bus8.start = 1; bus8.a = 8'h40; bus8.b = 8'h40; bus8.cin = 0;
        dn_cnt = 0; sm = '0; co = 0; ov = 0;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(posedge clk); #1;
            if (bus8.done) begin
                dn_cnt++;
                sm = bus8.sum; co = bus8.cout; ov = bus8.ovf;
            end
            if (cyc == 2 || cyc == 5) begin
                bus8.start = 1; bus8.a = 8'h01; bus8.b = 8'h01;
            end else begin
                bus8.start = 0;
            end
        end
        check("busy_start_done_cnt", 32'(dn_cnt), 1);
        check("busy_start_sum",  32'(sm), 32'h80);
        check("busy_start_cout", 32'(co), 0);
        check("busy_start_ovf",  32'(ov), 1);

        // Reset in cycle 3 of a RUN aborts it.
        @(posedge clk); #1;
        bus8.start = 1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 0;
        @(posedge clk); #1;
        bus8.start = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 32'(bus8.busy), 0);
        check("abort_done", 32'(bus8.done), 0);
        check("abort_sum",  32'(bus8.sum), 0);
        check("abort_cout", 32'(bus8.cout), 0);
        check("abort_ovf",  32'(bus8.ovf), 0);
        rst = 1'b0;
        dn_cnt = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk); #1;
            if (bus8.done) dn_cnt++;
        end
        check("abort_no_done", 32'(dn_cnt), 0);
        op8(8'h33, 8'h44, 1'b1, 1'b0, dcyc, bcnt, sm, co, ov);
        check("after_abort_done_cyc", 32'(dcyc), 9);
        check("after_abort_sum", 32'(sm), 32'h78);
        check("after_abort_cout", 32'(co), 0);

        // Exhaustive back-to-back on the 4/2 adder: start held, result every 3 cycles.
        @(posedge clk); #1;
        bus4.start = 1;
        k9 = 9'd0;
        {bus4.a, bus4.b, bus4.cin} = k9;
        for (int k = 0; k < 512; k++) begin
            k9 = 9'(k);
            {ea, eb, ec} = k9;
            tmp  = 5'(ea) + 5'(eb) + 5'(ec);
            eovf = (ea[3] == eb[3]) && (tmp[3] != ea[3]);
            @(posedge clk); #1; b1 = bus4.busy;
            @(posedge clk); #1; b2 = bus4.busy;
            @(posedge clk); #1; dn = bus4.done;
            check($sformatf("b2b_%0d", k),
                  32'({b1, b2, dn, bus4.ovf, bus4.cout, bus4.sum}),
                  32'({3'b111, eovf, tmp}));
            if (k < 511) begin
                k9 = 9'(k + 1);
                {bus4.a, bus4.b, bus4.cin} = k9;
            end else begin
                bus4.start = 0;
            end
        end

        // Single-step configuration (STEPS = 1).
        @(posedge clk); #1;
        bus88.start = 1; bus88.a = 8'hAA; bus88.b = 8'h55; bus88.cin = 1;
        @(posedge clk); #1;
        bus88.start = 0;
        check("s1_c1_busy", 32'(bus88.busy), 1);
        check("s1_c1_done", 32'(bus88.done), 0);
        @(posedge clk); #1;
        check("s1_c2_done", 32'(bus88.done), 1);
        check("s1_sum",  32'(bus88.sum), 0);
        check("s1_cout", 32'(bus88.cout), 1);
        check("s1_ovf",  32'(bus88.ovf), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
